// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome plus predictor state and indexing mode.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } PredState;

    typedef enum logic {
        BIMODAL = 1'b0,
        GSHARE  = 1'b1
    } PredMode;

endpackage

// File: rtl/branch_predictor_table_if.sv
// Request/feedback bundle between branch_controller and the predictor table.
interface branch_predictor_table_if
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int STAT_BITS  = 32
) ();

    logic                  i_clear;
    logic                  o_ready;
    logic                  i_req_valid;
    logic [ADDR_WIDTH-1:0] i_req_pc;
    logic [ADDR_WIDTH-1:0] i_req_target;
    BranchOutcome          o_req_prediction;
    logic                  i_fb_valid;
    logic [ADDR_WIDTH-1:0] i_fb_pc;
    BranchOutcome          i_fb_prediction;
    BranchOutcome          i_fb_outcome;
    logic [STAT_BITS-1:0]  o_fb_count;
    logic [STAT_BITS-1:0]  o_mispredict_count;

    modport master (
        output i_clear, i_req_valid, i_req_pc, i_req_target,
               i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        input  o_ready, o_req_prediction, o_fb_count, o_mispredict_count
    );

    modport slave (
        input  i_clear, i_req_valid, i_req_pc, i_req_target,
               i_fb_valid, i_fb_pc, i_fb_prediction, i_fb_outcome,
        output o_ready, o_req_prediction, o_fb_count, o_mispredict_count
    );

endinterface

// File: rtl/sat_counter_update.sv
// Next value of a saturating up/down counter for one resolved branch.
module sat_counter_update
    import mips_core_pkg::*;
#(
    parameter int COUNTER_BITS = 2
) (
    input  logic [COUNTER_BITS-1:0] value,
    input  BranchOutcome            outcome,
    output logic [COUNTER_BITS-1:0] next_value
);

    // Step toward the outcome, holding at either end.
    always_comb begin
        next_value = value;
        if (outcome == TAKEN) begin
            if (value != '1) next_value = value + COUNTER_BITS'(1);
        end else begin
            if (value != '0) next_value = value - COUNTER_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Table of saturating counters indexed bimodally or gshare-style, with an
// init sweep after reset/clear and feedback/mispredict statistics.
module branch_predictor_table
    import mips_core_pkg::*;
#(
    parameter int      ADDR_WIDTH   = 32,
    parameter int      INDEX_BITS   = 8,
    parameter int      COUNTER_BITS = 2,
    parameter int      HIST_BITS    = 8,
    parameter PredMode MODE         = GSHARE,
    parameter int      STAT_BITS    = 32
) (
    input logic                     clk,
    input logic                     rst,
    branch_predictor_table_if.slave bus
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] WEAK_NT =
        COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);

    if (COUNTER_BITS < 2 || COUNTER_BITS > 4) begin : g_bad_counter_bits
        $error("COUNTER_BITS must be 2..4");
    end
    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist_bits
        $error("HIST_BITS must be 1..INDEX_BITS");
    end
    if (ADDR_WIDTH < INDEX_BITS + 2) begin : g_bad_addr_width
        $error("ADDR_WIDTH too narrow for INDEX_BITS");
    end

    PredState                state_q, state_d;
    logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
    logic [HIST_BITS-1:0]    hist_q, hist_d;
    logic [STAT_BITS-1:0]    fb_cnt_q, fb_cnt_d;
    logic [STAT_BITS-1:0]    mis_cnt_q, mis_cnt_d;
    logic                    ready_q, ready_d;

    logic [COUNTER_BITS-1:0] table_q [ENTRIES];

    logic [INDEX_BITS-1:0]   hist_ext;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [INDEX_BITS-1:0]   fb_idx;
    logic [COUNTER_BITS-1:0] req_ctr;
    logic [COUNTER_BITS-1:0] fb_next;
    logic                    fb_accept;
    logic                    wr_en;
    logic [INDEX_BITS-1:0]   wr_idx;
    logic [COUNTER_BITS-1:0] wr_val;

    // Both indices use the history as it stands before this cycle's feedback.
    always_comb begin
        hist_ext = (MODE == GSHARE) ? INDEX_BITS'(hist_q) : '0;
        req_idx  = bus.i_req_pc[INDEX_BITS+1:2] ^ hist_ext;
        fb_idx   = bus.i_fb_pc[INDEX_BITS+1:2] ^ hist_ext;
        req_ctr  = table_q[req_idx];
    end

    sat_counter_update #(
        .COUNTER_BITS (COUNTER_BITS)
    ) u_sat (
        .value      (table_q[fb_idx]),
        .outcome    (bus.i_fb_outcome),
        .next_value (fb_next)
    );

    // Single table write port: sweep writes in INIT, training writes in READY.
    always_comb begin
        fb_accept = (state_q == READY) && bus.i_fb_valid && !bus.i_clear;
        if (state_q == INIT) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            wr_val = WEAK_NT;
        end else begin
            wr_en  = fb_accept;
            wr_idx = fb_idx;
            wr_val = fb_next;
        end
    end

    // Sweep sequencing, history shift and statistics.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hist_d    = hist_q;
        fb_cnt_d  = fb_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (bus.i_clear) begin
            state_d   = INIT;
            ptr_d     = '0;
            hist_d    = '0;
            fb_cnt_d  = '0;
            mis_cnt_d = '0;
        end else if (state_q == INIT) begin
            ptr_d = ptr_q + INDEX_BITS'(1);
            if (ptr_q == '1) state_d = READY;
        end else if (fb_accept) begin
            // Truncating {hist, outcome} also covers the single-bit history.
            hist_d = HIST_BITS'({hist_q, bus.i_fb_outcome == TAKEN});
            if (fb_cnt_q != '1) fb_cnt_d = fb_cnt_q + STAT_BITS'(1);
            if (bus.i_fb_prediction != bus.i_fb_outcome && mis_cnt_q != '1)
                mis_cnt_d = mis_cnt_q + STAT_BITS'(1);
        end
        ready_d = (state_d == READY);
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            ptr_q     <= '0;
            hist_q    <= '0;
            fb_cnt_q  <= '0;
            mis_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hist_q    <= hist_d;
            fb_cnt_q  <= fb_cnt_d;
            mis_cnt_q <= mis_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Counter storage; contents are defined by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_idx] <= wr_val;
    end

    assign bus.o_ready            = ready_q;
    assign bus.o_req_prediction   = (state_q == READY && req_ctr[COUNTER_BITS-1])
                                    ? TAKEN : NOT_TAKEN;
    assign bus.o_fb_count         = fb_cnt_q;
    assign bus.o_mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Drives a bimodal and a gshare instance with identical stimulus and checks
// both against a behavioural table model.
module tb_branch_predictor_table;
    import mips_core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_table_if #(.ADDR_WIDTH(32), .STAT_BITS(32)) bif ();
    branch_predictor_table_if #(.ADDR_WIDTH(32), .STAT_BITS(32)) gif ();

    branch_predictor_table #(.MODE(BIMODAL)) u_bim (.clk(clk), .rst(rst), .bus(bif));
    branch_predictor_table #(.MODE(GSHARE))  u_gsh (.clk(clk), .rst(rst), .bus(gif));

    int tests = 0;
    int fails = 0;

    // model: index 0 = bimodal, 1 = gshare
    int unsigned m_tab  [2][256];
    int unsigned m_hist [2];
    int unsigned m_fb   [2];
    int unsigned m_mis  [2];
    bit          m_ready;

    logic        last_pred [2];
    logic [31:0] last_fb   [2];
    logic [31:0] last_mis  [2];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned midx(int m, logic [31:0] pc);
        int unsigned base;
        base = (pc >> 2) & 32'hFF;
        return (m == 1) ? (base ^ m_hist[m]) : base;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) m_tab[m][i] = 1;
            m_hist[m] = 0;
            m_fb[m]   = 0;
            m_mis[m]  = 0;
        end
        m_ready = 0;
    endtask

    task automatic drive(logic clr, logic [31:0] rpc, logic fbv, logic [31:0] fpc,
                         BranchOutcome fpred, BranchOutcome fout);
        bif.i_clear = clr;         gif.i_clear = clr;
        bif.i_req_valid = 1'b1;    gif.i_req_valid = 1'b1;
        bif.i_req_pc = rpc;        gif.i_req_pc = rpc;
        bif.i_req_target = rpc + 32'h40; gif.i_req_target = rpc + 32'h40;
        bif.i_fb_valid = fbv;      gif.i_fb_valid = fbv;
        bif.i_fb_pc = fpc;         gif.i_fb_pc = fpc;
        bif.i_fb_prediction = fpred; gif.i_fb_prediction = fpred;
        bif.i_fb_outcome = fout;   gif.i_fb_outcome = fout;
    endtask

    task automatic sample_and_check(logic [31:0] rpc);
        logic o_rdy;
        last_pred[0] = bif.o_req_prediction; last_pred[1] = gif.o_req_prediction;
        last_fb[0]   = bif.o_fb_count;       last_fb[1]   = gif.o_fb_count;
        last_mis[0]  = bif.o_mispredict_count; last_mis[1] = gif.o_mispredict_count;
        for (int m = 0; m < 2; m++) begin
            o_rdy = (m == 0) ? bif.o_ready : gif.o_ready;
            check($sformatf("pred[%0d] pc=%0h", m, rpc), 32'(last_pred[m]),
                  32'(m_ready && m_tab[m][midx(m, rpc)] >= 2));
            check($sformatf("ready[%0d]", m), 32'(o_rdy), 32'(m_ready));
            check($sformatf("fb_count[%0d]", m), last_fb[m], m_fb[m]);
            check($sformatf("mis_count[%0d]", m), last_mis[m], m_mis[m]);
        end
    endtask

    task automatic step(logic [31:0] rpc, logic fbv, logic [31:0] fpc,
                        BranchOutcome fpred, BranchOutcome fout);
        int unsigned i;
        @(negedge clk);
        drive(1'b0, rpc, fbv, fpc, fpred, fout);
        #1;
        sample_and_check(rpc);
        if (m_ready && fbv) begin
            for (int m = 0; m < 2; m++) begin
                i = midx(m, fpc);
                if (fout == TAKEN) m_tab[m][i] = (m_tab[m][i] < 3) ? m_tab[m][i] + 1 : 3;
                else               m_tab[m][i] = (m_tab[m][i] > 0) ? m_tab[m][i] - 1 : 0;
                m_hist[m] = ((m_hist[m] << 1) | (fout == TAKEN ? 1 : 0)) & 32'hFF;
                m_fb[m]++;
                if (fpred != fout) m_mis[m]++;
            end
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b1, 32'h40, NOT_TAKEN, TAKEN);
        #1;
        sample_and_check(32'h100);
        model_clear();
    endtask

    // Sample n: o_ready must be low for the first 256 samples after INIT begins.
    task automatic run_init(int n);
        for (int c = 1; c <= n; c++) begin
            m_ready = (c > 256);
            step(32'h100, (c <= 256) ? 1'b1 : 1'b0, $urandom, BranchOutcome'($urandom_range(0, 1)),
                 BranchOutcome'($urandom_range(0, 1)));
            if (c == 257) check("after_init_pc100_nt", 32'(last_pred[0]), 32'(NOT_TAKEN));
        end
    endtask

    task automatic tk(logic [31:0] pc, int n);
        for (int k = 0; k < n; k++) step(pc, 1'b1, pc, TAKEN, TAKEN);
    endtask

    task automatic nt(logic [31:0] pc, int n);
        for (int k = 0; k < n; k++) step(pc, 1'b1, pc, NOT_TAKEN, NOT_TAKEN);
    endtask

    initial begin
        drive(1'b0, 32'h100, 1'b0, 32'h0, NOT_TAKEN, NOT_TAKEN);
        model_clear();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        sample_and_check(32'h100);
        @(posedge clk);
        #2 rst = 1'b0;
        run_init(257);

        // saturation, bimodal view
        tk(32'h40, 2);
        step(32'h40, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("sat_taken_after_2", 32'(last_pred[0]), 32'(TAKEN));
        tk(32'h40, 5);
        nt(32'h40, 2);
        step(32'h40, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("sat_high_then_nt2", 32'(last_pred[0]), 32'(NOT_TAKEN));
        nt(32'h40, 5);
        tk(32'h40, 1);
        step(32'h40, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("no_underflow", 32'(last_pred[0]), 32'(NOT_TAKEN));

        // aliasing
        tk(32'h40, 2);
        step(32'h440, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("alias_440_taken", 32'(last_pred[0]), 32'(TAKEN));
        step(32'h44, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("neighbour_44_nt", 32'(last_pred[0]), 32'(NOT_TAKEN));

        // same-cycle read before write
        step(32'h80, 1'b1, 32'h80, NOT_TAKEN, TAKEN);
        check("rbw_same_cycle_nt", 32'(last_pred[0]), 32'(NOT_TAKEN));
        step(32'h80, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("rbw_next_cycle_t", 32'(last_pred[0]), 32'(TAKEN));

        // clear mid-sweep restarts it, then stats
        do_clear();
        run_init(100);
        do_clear();
        run_init(257);
        check("cleared_fb_count", last_fb[0], 32'd0);
        for (int k = 0; k < 10; k++)
            step(32'h200 + 32'(k * 4), 1'b1, 32'h200 + 32'(k * 4),
                 (k < 3) ? TAKEN : NOT_TAKEN, NOT_TAKEN);
        step(32'h0, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("stats_fb_10", last_fb[0], 32'd10);
        check("stats_mis_3", last_mis[1], 32'd3);

        // gshare history
        do_clear();
        run_init(257);
        check("cleared_mis_count", last_mis[1], 32'd0);
        step(32'h0, 1'b1, 32'h400, TAKEN, TAKEN);
        step(32'h0, 1'b1, 32'h400, TAKEN, NOT_TAKEN);
        step(32'h0, 1'b1, 32'h400, TAKEN, TAKEN);
        check("gshare_hist_101", m_hist[1], 32'd5);
        step(32'h0, 1'b1, 32'h0, TAKEN, TAKEN);
        check("gshare_idx5_pre_nt", 32'(last_pred[1]), 32'(NOT_TAKEN));
        step(32'h38, 1'b0, 0, NOT_TAKEN, NOT_TAKEN);
        check("gshare_idx5_taken", 32'(last_pred[1]), 32'(TAKEN));

        // randomized traffic over a small PC set to force reuse and aliasing
        for (int k = 0; k < 500; k++) begin
            logic [31:0] rpc, fpc;
            rpc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            fpc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
            step(rpc, 1'($urandom_range(0, 1)), fpc,
                 BranchOutcome'($urandom_range(0, 1)), BranchOutcome'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised successor to the single-counter 2-bit predictor: a table of 2^INDEX_BITS saturating counters, each COUNTER_BITS wide.
- Indexed bimodally (PC only) or gshare-style (PC XOR global history), selected by MODE.
- Sits in branch_controller in place of the fixed predictor, with the same request/feedback interface plus table-init status and misprediction statistics.
- Clears its table with a sequential sweep after reset or on request.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (32): PC width.
- INDEX_BITS, 8: log2 of table entries.
- COUNTER_BITS, 2: counter width, legal range 2..4.
- HIST_BITS, 8: global history length, legal range 1..INDEX_BITS.
- MODE, 1: 0 = bimodal, 1 = gshare.
- STAT_BITS, 32: statistics counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_clear  in  1  synchronous request to re-initialise table and history
- o_ready  out  1  table initialised and predicting
- i_req_valid  in  1  prediction request (conditional branch in decode)
- i_req_pc  in  ADDR_WIDTH  PC of branch being predicted
- i_req_target  in  ADDR_WIDTH  decoded target (unused; kept for interface compatibility)
- o_req_prediction  out  BranchOutcome  predicted outcome
- i_fb_valid  in  1  resolved-branch feedback
- i_fb_pc  in  ADDR_WIDTH  PC of resolved branch
- i_fb_prediction  in  BranchOutcome  prediction that was made for it
- i_fb_outcome  in  BranchOutcome  actual outcome
- o_fb_count  out  STAT_BITS  accepted feedback events
- o_mispredict_count  out  STAT_BITS  accepted feedback with prediction != outcome

Behaviour:
Reset (rst high, async):
- state = INIT, sweep pointer = 0, history = 0, both stat counters = 0, o_ready = 0.

INIT state:
- One table entry is written per cycle with WEAK_NT = 2^(COUNTER_BITS-1)-1, in ascending index order.
- After the write to index 2^INDEX_BITS-1, the next state is READY; o_ready goes 1 on the following cycle.
- INIT therefore lasts exactly 2^INDEX_BITS cycles after rst deasserts.
- In INIT, o_req_prediction = NOT_TAKEN and i_fb_valid is ignored: no table, history or stat update.

READY state:
- i_clear high causes, on the next edge: state = INIT, pointer = 0, history = 0. Stat counters are cleared as well.
- i_clear asserted during INIT restarts the sweep from 0.

Index:
- pc_idx = pc[INDEX_BITS+1:2].
- MODE 0: idx = pc_idx.
- MODE 1: idx = pc_idx XOR zero-extended history.

Prediction:
- Combinational, same cycle: TAKEN iff MSB of table[req_idx] = 1, otherwise NOT_TAKEN.
- Computed for every cycle; i_req_valid only qualifies it.

Feedback (READY and i_fb_valid):
- fb_idx is computed with the history value before this cycle's update.
- Counter update, saturating: TAKEN increments unless already all-ones; NOT_TAKEN decrements unless already 0.
- History update: history <= {history[HIST_BITS-2:0], outcome==TAKEN}. For HIST_BITS = 1, the history is simply the outcome.
- History is non-speculative: updated only on feedback.
- o_fb_count increments, saturating at all-ones.
- o_mispredict_count increments, saturating, iff i_fb_prediction != i_fb_outcome.

Simultaneous request and feedback in one cycle:
- The prediction reads pre-update table and history (read-before-write), even when req_idx == fb_idx.
- The updated value is visible from the next cycle.

Other rules:
- No X on outputs during INIT or after reset.
- A reset asserted mid-sweep restarts INIT from index 0.

Decomposition:
- Shared package mips_core_pkg: BranchOutcome is already there.
- Add to the package: a PredState enum (INIT, READY) and a PredMode enum (BIMODAL = 0, GSHARE = 1).
- Sub-module sat_counter_update: combinational next-value function, parametrised by COUNTER_BITS, with inputs value and outcome.
- Table storage, sweep FSM, history register and statistics stay in the top module.

Test Plan:
- Reset then init: rst pulse; o_ready = 0 for exactly 256 cycles (INDEX_BITS = 8), then 1. A request at pc 0x100 during and after init -> NOT_TAKEN.
- Saturation, MODE 0: feedback TAKEN ×2 for pc 0x40 -> prediction TAKEN. ×5 more -> counter stays 3. NOT_TAKEN ×2 -> NOT_TAKEN. ×5 more -> counter 0, no underflow.
- Aliasing, MODE 0: TAKEN ×2 on pc 0x40 -> pc 0x440 (same index) predicts TAKEN; pc 0x44 still NOT_TAKEN.
- Gshare history, MODE 1: feedback outcomes T, N, T -> history = 0b101. A request at pc 0x0 reads index 5; train TAKEN there and check prediction TAKEN.
- Same-cycle read/write, MODE 0: with counter at 1 for pc 0x80, request and TAKEN feedback for 0x80 in one cycle -> NOT_TAKEN that cycle, TAKEN the next.
- Stats and clear: 10 feedbacks, 3 with prediction != outcome -> counts 10 and 3. i_clear -> counts 0, o_ready low for 256 cycles. Feedback during INIT is ignored (counts stay 0).
